// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with data-memory req/ack sequencing
//
// Sits between the EX/MEM pipeline register and the data-memory port.
// Stores are narrowed to byte/half lanes with byte enables; loads are lane-extracted
// and sign/zero-extended. The pipeline is stalled until the memory access completes.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_mem_op_valid        load/store present in MEM stage
//   i_mem_op_write        1=store, 0=load
//   i_mem_size            00 byte, 01 half, 10 word, 11 illegal
//   i_mem_unsigned        load extension: 1=zero, 0=sign
//   i_addr, i_wdata       byte address, store data
//   o_stall               freeze upstream pipeline
//   o_rdata_out           extended load result (held until next load or timeout)
//   o_done                one-cycle pulse, access complete
//   o_misalign            one-cycle pulse, rejected access
//   o_bus_err             one-cycle pulse with o_done, ack timeout
//   o_dm_req/we/addr/be/wdata, i_dm_ack, i_dm_rdata   data-memory port
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_op_valid,
    input  logic        i_mem_op_write,
    input  logic [1:0]  i_mem_size,
    input  logic        i_mem_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata_out,
    output logic        o_done,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_dm_req,
    output logic        o_dm_we,
    output logic [31:0] o_dm_addr,
    output logic [3:0]  o_dm_be,
    output logic [31:0] o_dm_wdata,
    input  logic        i_dm_ack,
    input  logic [31:0] i_dm_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter value seen in the last BUSY cycle before the access is abandoned.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_dm_wdata;
    logic [15:0] r_cnt;
    logic        r_timeout;
    logic        r_misalign;
    logic [31:0] r_rdata;

    logic        w_illegal;
    logic        w_accept;
    logic        w_reject;
    logic        w_busy;
    logic        w_expire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    assign w_illegal = (i_mem_size == 2'b11)
                     | ((i_mem_size == 2'b01) & i_addr[0])
                     | ((i_mem_size == 2'b10) & (i_addr[1:0] != 2'b00));
    assign w_accept  = (r_state == S_IDLE) & i_mem_op_valid & ~w_illegal;
    assign w_reject  = (r_state == S_IDLE) & i_mem_op_valid & w_illegal;
    assign w_busy    = (r_state == S_BUSY);
    // An ack arriving on the expiry cycle wins: the access completes normally.
    assign w_expire  = w_busy & ~i_dm_ack & (r_cnt == TMO_LAST);

    // Store lane placement, computed from the incoming op and latched at accept.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        case (i_mem_size)
            2'b00: begin
                w_wdata = {4{i_wdata[7:0]}};
                if (i_mem_op_write) w_be = 4'b0001 << i_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{i_wdata[15:0]}};
                if (i_mem_op_write) w_be = i_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load lane extraction and extension from the returned word.
    assign w_ld_byte = i_dm_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_ld_half = i_dm_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_data = i_dm_rdata;
        case (r_size)
            2'b00:   w_ld_data = r_unsigned ? {24'd0, w_ld_byte}
                                            : {{24{w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_data = r_unsigned ? {16'd0, w_ld_half}
                                            : {{16{w_ld_half[15]}}, w_ld_half};
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        o_stall  = 1'b0;
        o_dm_req = 1'b0;
        o_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next  = S_BUSY;
                    o_stall = 1'b1;
                end
            end
            S_BUSY: begin
                o_stall  = 1'b1;
                o_dm_req = 1'b1;
                if (i_dm_ack || w_expire) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_be       <= 4'd0;
            r_dm_wdata <= 32'd0;
            r_cnt      <= 16'd0;
            r_timeout  <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_misalign <= w_reject;
            if (w_accept) begin
                r_we       <= i_mem_op_write;
                r_size     <= i_mem_size;
                r_unsigned <= i_mem_unsigned;
                r_addr     <= i_addr;
                r_be       <= w_be;
                r_dm_wdata <= w_wdata;
            end
            if (w_busy && !i_dm_ack) r_cnt <= r_cnt + 16'd1;
            else if (r_state == S_DONE) r_cnt <= 16'd0;
            // Timeout flag is held through DONE so bus_err pulses alongside done.
            if (w_busy) r_timeout <= w_expire;
            else if (r_state == S_IDLE) r_timeout <= 1'b0;
            if (w_busy && !r_we) begin
                if (i_dm_ack)      r_rdata <= w_ld_data;
                else if (w_expire) r_rdata <= 32'd0;
            end
        end
    end

    assign o_rdata_out = r_rdata;
    assign o_misalign  = r_misalign;
    assign o_bus_err   = (r_state == S_DONE) & r_timeout;
    assign o_dm_we     = w_busy & r_we;
    assign o_dm_addr   = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
    assign o_dm_be     = w_busy ? r_be : 4'd0;
    assign o_dm_wdata  = w_busy ? r_dm_wdata : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int TMO = 4;
    localparam int NOACK = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_write, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign, bus_err, dm_req, dm_we, dm_ack;
    logic [31:0] rdata_out, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_rdata;

    int          obs_stall, obs_lat, obs_done, obs_bus, obs_mis, obs_req, obs_unstable;
    logic        obs_we;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mem_op_valid(op_valid), .i_mem_op_write(op_write), .i_mem_size(size),
        .i_mem_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
        .o_stall(stall), .o_rdata_out(rdata_out), .o_done(done),
        .o_misalign(misalign), .o_bus_err(bus_err),
        .o_dm_req(dm_req), .o_dm_we(dm_we), .o_dm_addr(dm_addr), .o_dm_be(dm_be),
        .o_dm_wdata(dm_wdata), .i_dm_ack(dm_ack), .i_dm_rdata(dm_rdata)
    );

    // Reference model: lane rules expressed as plain arithmetic.
    function automatic logic m_illegal(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic w, input logic [1:0] sz, input logic [31:0] a);
        if (!w || sz == 2) return 4'hF;
        if (sz == 0) return 4'(1 << (a % 4));
        return ((a % 4) >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Presents one op for one cycle, acks after 'waits' BUSY cycles (plus stray acks
    // in the DONE and following IDLE cycle), and records what the DUT did.
    task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits);
        obs_stall = 0; obs_lat = -1; obs_done = 0; obs_bus = 0; obs_mis = 0;
        obs_req = 0; obs_unstable = 0;
        @(posedge clk); #1;
        op_valid = 1'b1; op_write = w; size = sz; uns = u; addr = a; wdata = wd;
        for (int c = 0; c < 14; c++) begin
            dm_ack   = (c >= waits + 1) && (c <= waits + 3);
            dm_rdata = (c == waits + 1) ? rd : $urandom;
            @(negedge clk);
            if (stall) obs_stall++;
            if (misalign) obs_mis++;
            if (bus_err) obs_bus++;
            if (done) begin
                obs_done++;
                if (obs_lat < 0) obs_lat = c;
            end
            if (dm_req) begin
                if (obs_req == 0) begin
                    obs_we = dm_we; obs_addr = dm_addr; obs_be = dm_be; obs_wdata = dm_wdata;
                end else if ({obs_we, obs_addr, obs_be, obs_wdata} !== {dm_we, dm_addr, dm_be, dm_wdata}) begin
                    obs_unstable = 1;
                end
                obs_req++;
            end
            @(posedge clk); #1;
            op_valid = 1'b0; op_write = $urandom; size = $urandom; uns = $urandom;
            addr = $urandom; wdata = $urandom;
        end
        dm_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, done, misalign, bus_err, dm_req, dm_we, dm_be, dm_addr, dm_wdata, rdata_out} !== '0)
            begin errors++; $display("FAIL reset_outputs: got stall=%b done=%b req=%b be=%h rdata=%h, required all 0", stall, done, dm_req, dm_be, rdata_out); end
        #1 rst = 1'b0;
        exp_rdata = 32'd0;
    endtask

    task automatic test_load_byte_signed;
        run_op(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80112233, 0);
        checks++; if (obs_be !== 4'hF) begin errors++; $display("FAIL lb_be: got %h required f", obs_be); end
        checks++; if (obs_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr: got %h required 00001000", obs_addr); end
        checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b required 0", obs_we); end
        checks++; if (rdata_out !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h required ffffff80", rdata_out); end
        checks++; if (obs_lat != 2) begin errors++; $display("FAIL lb_latency: got %0d required 2", obs_lat); end
        checks++; if (obs_stall != 2) begin errors++; $display("FAIL lb_stall: got %0d required 2", obs_stall); end
        checks++; if (obs_done != 1) begin errors++; $display("FAIL lb_done_pulses: got %0d required 1", obs_done); end
        exp_rdata = 32'hFFFFFF80;
    endtask

    task automatic test_load_half_unsigned;
        // Ack lands on the cycle the timeout would expire: must count as success.
        run_op(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'hBEEF1234, 3);
        checks++; if (rdata_out !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_rdata: got %h required 0000beef", rdata_out); end
        checks++; if (obs_stall != 5) begin errors++; $display("FAIL lhu_stall: got %0d required 5", obs_stall); end
        checks++; if (obs_lat != 5) begin errors++; $display("FAIL lhu_latency: got %0d required 5", obs_lat); end
        checks++; if (obs_done != 1) begin errors++; $display("FAIL lhu_done_pulses: got %0d required 1", obs_done); end
        checks++; if (obs_bus != 0) begin errors++; $display("FAIL lhu_bus_err: got %0d required 0", obs_bus); end
        exp_rdata = 32'h0000BEEF;
    endtask

    task automatic test_store;
        run_op(1'b1, 2'b00, 1'b0, 32'h3001, 32'h123456AB, 32'h0, 2);
        checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b required 1", obs_we); end
        checks++; if (obs_be !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b required 0010", obs_be); end
        checks++; if (obs_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata: got %h required abababab", obs_wdata); end
        checks++; if (obs_unstable != 0 || obs_req != 3) begin errors++; $display("FAIL sb_hold: got unstable=%0d req_cycles=%0d required 0 and 3", obs_unstable, obs_req); end
        run_op(1'b1, 2'b01, 1'b0, 32'h3002, 32'h0000CAFE, 32'h0, 0);
        checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'hCAFECAFE) begin errors++; $display("FAIL sh_lanes: got be=%b wdata=%h required 1100 cafecafe", obs_be, obs_wdata); end
        run_op(1'b1, 2'b10, 1'b0, 32'h3004, 32'h89ABCDEF, 32'h0, 1);
        checks++; if (obs_be !== 4'hF || obs_wdata !== 32'h89ABCDEF || obs_addr !== 32'h3004) begin errors++; $display("FAIL sw_lanes: got be=%h wdata=%h addr=%h required f 89abcdef 00003004", obs_be, obs_wdata, obs_addr); end
        checks++; if (rdata_out !== exp_rdata) begin errors++; $display("FAIL store_rdata_hold: got %h required %h", rdata_out, exp_rdata); end
    endtask

    task automatic test_misalign;
        run_op(1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, 32'h11111111, 0);
        checks++; if (obs_mis != 1 || obs_req != 0 || obs_stall != 0 || obs_done != 0) begin errors++; $display("FAIL mis_word: got mis=%0d req=%0d stall=%0d done=%0d required 1 0 0 0", obs_mis, obs_req, obs_stall, obs_done); end
        run_op(1'b0, 2'b11, 1'b0, 32'h4000, 32'h0, 32'h22222222, 0);
        checks++; if (obs_mis != 1 || obs_req != 0 || obs_stall != 0 || obs_done != 0) begin errors++; $display("FAIL mis_size3: got mis=%0d req=%0d stall=%0d done=%0d required 1 0 0 0", obs_mis, obs_req, obs_stall, obs_done); end
        checks++; if (rdata_out !== exp_rdata) begin errors++; $display("FAIL mis_rdata_hold: got %h required %h", rdata_out, exp_rdata); end
    endtask

    task automatic test_timeout;
        run_op(1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 32'h0, NOACK);
        checks++; if (obs_lat != TMO + 1) begin errors++; $display("FAIL tmo_latency: got %0d required %0d", obs_lat, TMO + 1); end
        checks++; if (obs_bus != 1 || obs_done != 1) begin errors++; $display("FAIL tmo_pulses: got bus_err=%0d done=%0d required 1 1", obs_bus, obs_done); end
        checks++; if (rdata_out !== 32'd0) begin errors++; $display("FAIL tmo_rdata: got %h required 0", rdata_out); end
        exp_rdata = 32'd0;
    endtask

    task automatic test_random;
        logic        w, u;
        logic [1:0]  sz;
        logic [31:0] a, wd, rd;
        int          waits;
        for (int i = 0; i < 40; i++) begin
            w = $urandom; u = $urandom; wd = $urandom; rd = $urandom;
            waits = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0) begin
                sz = $urandom; a = $urandom;
            end else begin
                sz = 2'($urandom_range(0, 2));
                a = ($urandom & 32'hFFFF_FFFC) + ((sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0);
            end
            run_op(w, sz, u, a, wd, rd, waits);
            if (m_illegal(sz, a)) begin
                checks++; if (obs_mis != 1 || obs_req != 0 || obs_done != 0) begin errors++; $display("FAIL rnd_illegal[%0d]: got mis=%0d req=%0d done=%0d required 1 0 0", i, obs_mis, obs_req, obs_done); end
            end else begin
                if (!w) exp_rdata = m_load(sz, u, a, rd);
                checks++; if (obs_lat != waits + 2 || obs_stall != waits + 2 || obs_done != 1 || obs_bus != 0) begin errors++; $display("FAIL rnd_timing[%0d]: got lat=%0d stall=%0d done=%0d bus=%0d required %0d %0d 1 0", i, obs_lat, obs_stall, obs_done, obs_bus, waits + 2, waits + 2); end
                checks++; if (obs_we !== w || obs_be !== m_be(w, sz, a) || obs_addr !== (a & 32'hFFFF_FFFC) || obs_unstable != 0) begin errors++; $display("FAIL rnd_req[%0d]: got we=%b be=%h addr=%h unstable=%0d required %b %h %h 0", i, obs_we, obs_be, obs_addr, obs_unstable, w, m_be(w, sz, a), a & 32'hFFFF_FFFC); end
                if (w) begin
                    checks++; if (obs_wdata !== m_wdata(sz, wd)) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h required %h", i, obs_wdata, m_wdata(sz, wd)); end
                end
                checks++; if (rdata_out !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h required %h", i, rdata_out, exp_rdata); end
            end
        end
    endtask

    task automatic test_reset_mid_busy;
        int late_done;
        late_done = 0;
        @(posedge clk); #1;
        op_valid = 1'b1; op_write = 1'b1; size = 2'b10; uns = 1'b0;
        addr = 32'h6000; wdata = 32'h5A5A5A5A; dm_ack = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL rstb_busy: got dm_req=%b required 1", dm_req); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({stall, done, misalign, bus_err, dm_req, dm_we, dm_be, dm_addr, dm_wdata, rdata_out} !== '0)
            begin errors++; $display("FAIL rstb_outputs: got stall=%b done=%b req=%b be=%h rdata=%h, required all 0", stall, done, dm_req, dm_be, rdata_out); end
        dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || dm_req || stall) late_done++;
            @(posedge clk); #1;
            dm_ack = 1'b0;
        end
        checks++; if (late_done != 0) begin errors++; $display("FAIL rstb_late_ack: got %0d active cycles required 0", late_done); end
        exp_rdata = 32'd0;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_write = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'd0; wdata = 32'd0; dm_ack = 1'b0; dm_rdata = 32'd0;
        test_reset;
        test_load_byte_signed;
        test_load_half_unsigned;
        test_store;
        test_misalign;
        test_timeout;
        test_random;
        test_reset_mid_busy;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
